// File: rtl/theta_sweep_reader.sv
// theta_sweep_reader: tracks rotor speed from the hall index and reads one frame-buffer column pair per slice
module theta_sweep_reader #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int DISPLAY_RADIUS = 32,
    parameter int DISPLAY_HEIGHT = 64,
    parameter int DATA_SIZE      = 1,
    parameter int READ_LATENCY   = 2,
    parameter int PERIOD_W       = 28
) (
    input  logic                                            clk_in,
    input  logic                                            rst_in,
    input  logic                                            index_in,
    output logic [$clog2(ROTATIONAL_RES)-1:0]               theta_read,
    input  logic [1:0][DISPLAY_HEIGHT*DATA_SIZE-1:0]        columns,
    input  logic [1:0][$clog2(DISPLAY_RADIUS)-1:0]          radii,
    output logic [1:0][DISPLAY_HEIGHT*DATA_SIZE-1:0]        col_out,
    output logic [1:0][$clog2(DISPLAY_RADIUS)-1:0]          radii_out,
    output logic [$clog2(ROTATIONAL_RES)-1:0]               slice_theta,
    output logic                                            col_valid,
    output logic                                            spinning
);
    localparam int TW  = $clog2(ROTATIONAL_RES);
    localparam int LW  = $clog2(READ_LATENCY + 1);
    localparam int CW  = DISPLAY_HEIGHT * DATA_SIZE;
    localparam int RDW = $clog2(DISPLAY_RADIUS);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(ROTATIONAL_RES * (READ_LATENCY + 1));
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
    localparam logic [TW-1:0]       THETA_MAX  = TW'(ROTATIONAL_RES - 1);
    localparam logic [LW-1:0]       LAT_LOAD   = LW'(READ_LATENCY);

    typedef enum logic [1:0] {STOPPED, SYNC, RUN} state_t;

    logic [2:0]          sync_q, sync_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d, period_reg_q, period_reg_d;
    logic [PERIOD_W-1:0] slice_tmr_q, slice_tmr_d, slice_len;
    logic [TW-1:0]       theta_q, theta_d, slice_theta_q, slice_theta_d;
    logic [LW-1:0]       lat_q, lat_d;
    state_t              state_q, state_d;
    logic [1:0][CW-1:0]  col_q, col_d;
    logic [1:0][RDW-1:0] radii_q, radii_d;
    logic                valid_q, valid_d;
    logic                idx_evt, sat, accept, slice_end, load, stop;

    // Next state: index qualification, slice stepping and the read-latency pipeline
    always_comb begin
        sync_d        = {sync_q[1:0], index_in};
        idx_evt       = sync_q[1] & ~sync_q[2];
        sat           = period_cnt_q == PERIOD_MAX;
        accept        = idx_evt && period_cnt_q >= MIN_PERIOD;
        slice_len     = period_reg_q >> TW;
        slice_end     = slice_tmr_q == slice_len - 1'b1;
        state_d       = state_q;
        period_cnt_d  = sat ? period_cnt_q : period_cnt_q + 1'b1;
        period_reg_d  = period_reg_q;
        slice_tmr_d   = slice_tmr_q;
        theta_d       = theta_q;
        col_d         = col_q;
        radii_d       = radii_q;
        slice_theta_d = slice_theta_q;
        load          = 1'b0;
        stop          = 1'b0;
        if (state_q == STOPPED) begin
            if (idx_evt) begin
                period_cnt_d = '0;
                state_d      = SYNC;
            end
        end else if (sat) begin
            // Saturation wins so a stale period can never reach period_reg
            stop    = 1'b1;
            state_d = STOPPED;
            theta_d = '0;
            col_d   = '0;
            radii_d = '0;
        end else if (accept) begin
            period_cnt_d = '0;
            period_reg_d = period_cnt_q + 1'b1;
            theta_d      = '0;
            slice_tmr_d  = '0;
            load         = 1'b1;
            state_d      = RUN;
        end else if (state_q == RUN) begin
            slice_tmr_d = slice_end ? '0 : slice_tmr_q + 1'b1;
            if (slice_end && theta_q != THETA_MAX) begin
                theta_d = theta_q + 1'b1;
                load    = 1'b1;
            end
        end
        lat_d   = load ? LAT_LOAD : stop ? '0 : lat_q - LW'(lat_q != '0);
        valid_d = lat_q == LW'(1) && !load && !stop;
        if (valid_d) begin
            col_d         = columns;
            radii_d       = radii;
            slice_theta_d = theta_q;
        end
    end

    // State registers, all cleared immediately by reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q        <= '0;
            period_cnt_q  <= '0;
            period_reg_q  <= '0;
            slice_tmr_q   <= '0;
            theta_q       <= '0;
            slice_theta_q <= '0;
            lat_q         <= '0;
            state_q       <= STOPPED;
            col_q         <= '0;
            radii_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            period_cnt_q  <= period_cnt_d;
            period_reg_q  <= period_reg_d;
            slice_tmr_q   <= slice_tmr_d;
            theta_q       <= theta_d;
            slice_theta_q <= slice_theta_d;
            lat_q         <= lat_d;
            state_q       <= state_d;
            col_q         <= col_d;
            radii_q       <= radii_d;
            valid_q       <= valid_d;
        end
    end

    assign theta_read  = theta_q;
    assign col_out     = col_q;
    assign radii_out   = radii_q;
    assign slice_theta = slice_theta_q;
    assign col_valid   = valid_q;
    assign spinning    = state_q == RUN;
endmodule

// File: tb/tb_theta_sweep_reader.sv
// tb_theta_sweep_reader: random index schedule against a revolution-level model with a strobe scoreboard
module tb_theta_sweep_reader;
    localparam int RES = 16;
    localparam int HW  = 64;
    localparam int RW  = 5;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 index_in = 1'b0;
    logic [3:0]           theta_read, slice_theta;
    logic [1:0][HW-1:0]   columns, col_out;
    logic [1:0][RW-1:0]   radii, radii_out;
    logic                 col_valid, spinning;

    theta_sweep_reader #(.ROTATIONAL_RES(RES), .READ_LATENCY(2), .PERIOD_W(12)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .index_in(index_in), .theta_read(theta_read),
        .columns(columns), .radii(radii), .col_out(col_out), .radii_out(radii_out),
        .slice_theta(slice_theta), .col_valid(col_valid), .spinning(spinning)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Frame buffer model: data for a theta is presented from the edge after the address changes
    logic [1:0][HW-1:0] colmem [RES];
    logic [1:0][RW-1:0] radmem [RES];
    logic [3:0]         addr_q = '0;
    always @(posedge clk_in) addr_q <= theta_read;
    assign columns = colmem[addr_q];
    assign radii   = radmem[addr_q];

    typedef struct {int t; int th; bit spin;} chg_t;
    typedef struct {int t; int th;} stb_t;
    chg_t chg[$];
    stb_t exp_q[$];
    stb_t got;
    int   rise[$];
    int   nr;
    int   compared = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic add(input int d);
        nr += d;
        rise.push_back(nr);
    endtask

    function automatic logic idx_level(input int c);
        foreach (rise[k]) if (c >= rise[k] && c < rise[k] + 10) return 1'b1;
        return 1'b0;
    endfunction

    task automatic emit_rev(input int rs, input int l, input int lim);
        for (int t = 0; t < RES; t++) if (rs + t * l < lim) chg.push_back('{rs + t * l, t, 1'b1});
    endtask

    // Revolution-level model: every accepted index starts a revolution of 16 slices of period/16 cycles
    task automatic build_model(input int end_t);
        int st, last, rs, l, e;
        st = 0; last = 0; rs = 0; l = 0;
        foreach (rise[k]) begin
            e = rise[k] + 3;
            if (st != 0 && e - last >= 4096) begin
                if (st == 2) emit_rev(rs, l, last + 4096);
                chg.push_back('{last + 4096, 0, 1'b0});
                st = 0;
            end
            if (st == 0) begin
                st = 1;
                last = e;
            end else if (e - last > 48) begin
                if (st == 2) emit_rev(rs, l, e);
                st = 2; l = (e - last) >> 4; rs = e; last = e;
            end
        end
        if (st == 2) emit_rev(rs, l, end_t);
    endtask

    // Monitor: every strobe must match the oldest outstanding expected slice
    always @(negedge clk_in) begin
        if (col_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected col_valid at cycle %0d: slice_theta %0d, expected no strobe", cyc, slice_theta);
            end else begin
                got = exp_q.pop_front();
                check("strobe_cycle", cyc, got.t);
                check("slice_theta", slice_theta, got.th);
                check("col_out", col_out, colmem[got.th]);
                check("radii_out", radii_out, radmem[got.th]);
                check("spinning_at_strobe", spinning, 1);
            end
        end
    end

    initial begin
        int p, end_t, cur_th, blank_at, s, nxt;
        bit cur_sp;
        for (int i = 0; i < RES; i++) begin
            colmem[i] = {$urandom, $urandom, $urandom, $urandom};
            radmem[i] = 10'($urandom);
        end
        repeat (3) @(negedge clk_in);
        check("reset theta_read", theta_read, 0);
        check("reset col_out", col_out, 0);
        check("reset radii_out", radii_out, 0);
        check("reset slice_theta", slice_theta, 0);
        check("reset col_valid", col_valid, 0);
        check("reset spinning", spinning, 0);
        rst_in = 1'b0;
        nr = cyc + 10;
        rise.push_back(nr);
        add(320); add(320); add(320);
        add(400); add(400);
        rise.push_back(nr + 30);
        add(400);
        repeat (4) begin
            add($urandom_range(280, 440));
            if ($urandom_range(0, 1) == 1) rise.push_back(nr + $urandom_range(20, 40));
        end
        add(320); add(320); add(301); add(320); add(320); add(300);
        add(4396);
        add(320); add(320);
        end_t = nr + 3 + 5 * 20 + 1;
        build_model(end_t);
        p = 0; cur_th = 0; cur_sp = 0; blank_at = -1;
        while (cyc < end_t - 1) begin
            @(negedge clk_in);
            index_in = idx_level(cyc);
            while (p < chg.size() && chg[p].t <= cyc) begin
                cur_th = chg[p].th;
                cur_sp = chg[p].spin;
                if (!cur_sp) blank_at = chg[p].t + 3;
                s = chg[p].t + 2;
                nxt = (p + 1 < chg.size()) ? chg[p + 1].t : end_t;
                if (cur_sp && s < nxt && s < end_t) exp_q.push_back('{s, cur_th});
                p++;
            end
            check("theta_read", theta_read, cur_th);
            check("spinning", spinning, cur_sp);
            if (cyc == blank_at) begin
                check("stopped col_out", col_out, 0);
                check("stopped radii_out", radii_out, 0);
            end
        end
        check("pre-reset col_out nonzero", col_out != '0, 1);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("async reset theta_read", theta_read, 0);
        check("async reset col_out", col_out, 0);
        check("async reset radii_out", radii_out, 0);
        check("async reset slice_theta", slice_theta, 0);
        check("async reset col_valid", col_valid, 0);
        check("async reset spinning", spinning, 0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (60) begin
            @(negedge clk_in);
            check("post-reset theta_read", theta_read, 0);
            check("post-reset spinning", spinning, 0);
        end
        check("outstanding strobes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
